// File: rtl/muldiv_seq.sv
// muldiv_seq
//   Iterative unsigned multiply/divide unit that sits beside the EXE-stage ALU
//   and handles RV32M MUL, MULHU, DIVU and REMU. It produces one result bit per
//   clock, stalls the pipeline while it works, and presents its result for a
//   single cycle.
//
//   Ports
//     clk_i     clock, rising edge
//     rst_i     synchronous active-high reset
//     start_i   EXE holds an M-op (level, held until valid_o)
//     op_i      00 MUL, 01 MULHU, 10 DIVU, 11 REMU (sampled with start_i)
//     op1_i     multiplicand / dividend
//     op2_i     multiplier / divisor
//     flush_i   squash the in-flight op
//     stall_o   freeze PC, IF/ID and ID/EXE
//     valid_o   result_o valid this cycle
//     result_o  selected result, held until the next completion or reset
module muldiv_seq #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [1:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic            flush_i,
    output logic            stall_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [1:0]          op_q;
    logic [XLEN-1:0]     mcand_q;
    logic [XLEN-1:0]     divisor_q;
    logic [XLEN-1:0]     quot_q;
    logic [2*XLEN-1:0]   prod_q;
    logic [XLEN:0]       rem_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     result_q;

    logic                launch;
    logic                divzero;
    logic                last;
    logic [XLEN:0]       add_sum;
    logic [2*XLEN-1:0]   prod_nxt;
    logic [XLEN:0]       rem_sh;
    logic [XLEN:0]       trial;
    logic                ge;
    logic [XLEN:0]       rem_nxt;
    logic [XLEN-1:0]     quot_nxt;

    function automatic logic [XLEN-1:0] sel_result(
        input logic [1:0]        op,
        input logic [2*XLEN-1:0] prod,
        input logic [XLEN-1:0]   quot,
        input logic [XLEN-1:0]   rem
    );
        case (op)
            2'b00:   return prod[XLEN-1:0];
            2'b01:   return prod[2*XLEN-1:XLEN];
            2'b10:   return quot;
            default: return rem;
        endcase
    endfunction

    assign launch  = start_i & ~flush_i;
    assign divzero = op_i[1] & (op2_i == '0);
    assign last    = (cnt_q == CNT_W'(XLEN - 1));

    // Shift-add multiply: the upper half accumulates with a carry bit, then the
    // whole register shifts right so the next multiplier bit lands in bit 0.
    always_comb begin
        add_sum  = {1'b0, prod_q[2*XLEN-1:XLEN]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
        prod_nxt = {add_sum, prod_q[XLEN-1:1]};
    end

    // Restoring divide: the partial remainder stays below the divisor, so the
    // shifted value fits XLEN+1 bits and the trial difference's MSB is its sign.
    always_comb begin
        rem_sh   = {rem_q[XLEN-1:0], quot_q[XLEN-1]};
        trial    = rem_sh - {1'b0, divisor_q};
        ge       = ~trial[XLEN];
        rem_nxt  = ge ? trial : rem_sh;
        quot_nxt = {quot_q[XLEN-2:0], ge};
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state     <= IDLE;
            op_q      <= '0;
            mcand_q   <= '0;
            divisor_q <= '0;
            quot_q    <= '0;
            prod_q    <= '0;
            rem_q     <= '0;
            cnt_q     <= '0;
            result_q  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (launch) begin
                        op_q      <= op_i;
                        mcand_q   <= op1_i;
                        divisor_q <= op2_i;
                        quot_q    <= op1_i;
                        prod_q    <= {{XLEN{1'b0}}, op2_i};
                        rem_q     <= '0;
                        cnt_q     <= '0;
                        if (divzero) begin
                            // RISC-V defined divide-by-zero results, no iterations
                            result_q <= op_i[0] ? op1_i : '1;
                            state    <= DONE;
                        end else begin
                            state <= CALC;
                        end
                    end
                end
                CALC: begin
                    if (flush_i) begin
                        state <= IDLE;
                    end else begin
                        prod_q <= prod_nxt;
                        rem_q  <= rem_nxt;
                        quot_q <= quot_nxt;
                        cnt_q  <= cnt_q + 1'b1;
                        if (last) begin
                            result_q <= sel_result(op_q, prod_nxt, quot_nxt, rem_nxt[XLEN-1:0]);
                            state    <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // A squash in CALC releases the pipeline in the same cycle.
    assign stall_o  = ((state == IDLE) & launch & ~divzero) | ((state == CALC) & ~flush_i);
    assign valid_o  = (state == DONE);
    assign result_o = result_q;

endmodule

// File: tb/tb_muldiv_seq.sv
module tb_muldiv_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] op1;
    logic [31:0] op2;
    logic        flush;
    logic        stall;
    logic        valid;
    logic [31:0] result;

    int checks = 0;
    int errors = 0;

    muldiv_seq #(.XLEN(32), .CNT_W(6)) dut (
        .clk_i    (clk),
        .rst_i    (rst),
        .start_i  (start),
        .op_i     (op),
        .op1_i    (op1),
        .op2_i    (op2),
        .flush_i  (flush),
        .stall_o  (stall),
        .valid_o  (valid),
        .result_o (result)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: plain RV32M arithmetic on 64-bit values.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] p;
        p = {32'd0, a} * {32'd0, b};
        case (o)
            2'b00:   return p[31:0];
            2'b01:   return p[63:32];
            2'b10:   return (b == 0) ? 32'hFFFF_FFFF : a / b;
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [31:0] exp;
        logic        dz;
        int          n;
        int          stall_cnt;
        logic        got;
        exp = model(o, a, b);
        dz  = o[1] && (b == 0);
        @(negedge clk);
        start = 1'b1; op = o; op1 = a; op2 = b;
        #1;
        chk({tag, "_launch_stall"}, stall, !dz);
        @(posedge clk);
        #1;
        op1 = $urandom; op2 = $urandom;
        n = 0; stall_cnt = 0; got = 1'b0;
        while (!got && n < 100) begin
            @(negedge clk);
            n++;
            if (valid) got = 1'b1;
            else if (stall) stall_cnt++;
        end
        chk({tag, "_got_valid"}, got, 1'b1);
        chk({tag, "_latency"}, n, dz ? 1 : 33);
        chk({tag, "_stall_cycles"}, stall_cnt, dz ? 0 : 32);
        chk({tag, "_result"}, result, exp);
        chk({tag, "_done_stall"}, stall, 1'b0);
        // start stays high across the edge leaving DONE: no relaunch expected
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        chk({tag, "_single_pulse"}, valid, 1'b0);
        chk({tag, "_idle_stall"}, stall, 1'b0);
        chk({tag, "_held"}, result, exp);
    endtask

    initial begin
        int pulses;
        logic [1:0]  ro;
        logic [31:0] ra;
        logic [31:0] rb;
        rst = 1'b1; start = 1'b0; op = 2'b00; op1 = '0; op2 = '0; flush = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("rst_valid", valid, 1'b0);
        chk("rst_stall", stall, 1'b0);
        chk("rst_result", result, 32'd0);

        do_op("mul_7x6", 2'b00, 32'd7, 32'd6);
        do_op("mulhu_ff", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("mul_ff", 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        do_op("divu_100_7", 2'b10, 32'd100, 32'd7);
        do_op("remu_100_7", 2'b11, 32'd100, 32'd7);
        do_op("divu_5_9", 2'b10, 32'd5, 32'd9);
        do_op("remu_5_9", 2'b11, 32'd5, 32'd9);
        do_op("divu_by0", 2'b10, 32'h1234, 32'd0);
        do_op("remu_by0", 2'b11, 32'h1234, 32'd0);
        do_op("divu_big", 2'b10, 32'hFFFF_FFFF, 32'd1);
        do_op("remu_big", 2'b11, 32'hFFFF_FFFE, 32'hFFFF_FFFF);

        // flush at CALC iteration 10
        @(negedge clk);
        start = 1'b1; op = 2'b00; op1 = 32'd1234; op2 = 32'd5678;
        @(posedge clk);
        repeat (10) @(negedge clk);
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("flush_valid", valid, 1'b0);
        chk("flush_stall", stall, 1'b0);
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid) pulses++;
        end
        chk("flush_no_pulse", pulses, 0);
        do_op("mul_3x5", 2'b00, 32'd3, 32'd5);

        // flush together with start in IDLE: no launch
        @(negedge clk);
        start = 1'b1; flush = 1'b1; op = 2'b00; op1 = 32'd9; op2 = 32'd9;
        #1;
        chk("flush_start_stall", stall, 1'b0);
        @(posedge clk);
        #1;
        start = 1'b0; flush = 1'b0;
        pulses = 0;
        repeat (40) begin
            @(negedge clk);
            if (valid || stall) pulses++;
        end
        chk("flush_start_nolaunch", pulses, 0);
        chk("flush_start_result", result, 32'd15);

        // reset in the middle of CALC
        @(negedge clk);
        start = 1'b1; op = 2'b01; op1 = 32'hDEAD_BEEF; op2 = 32'h1234_5678;
        @(posedge clk);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        chk("midrst_valid", valid, 1'b0);
        chk("midrst_stall", stall, 1'b0);
        chk("midrst_result", result, 32'd0);

        // randomized operations
        for (int i = 0; i < 24; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            if (i % 6 == 5)      rb = 32'd0;
            else if (i % 3 == 0) rb = 32'($urandom_range(1, 20));
            else                 rb = $urandom;
            do_op("rand", ro, ra, rb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
